// File: rtl/uart_rx_ctrl_if.sv
// Receiver-facing and host-facing signal bundle for uart_rx_ctrl.
// The master side is the surrounding system (receiver datapath plus host
// register block); the slave side is the controller.
interface uart_rx_ctrl_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    // receiver side
    logic                          rx_enable;
    logic [DATA_BITS-1:0]          rx_data;
    logic                          rx_data_ready;
    logic                          rx_frame_error;
    logic                          rx_overrun;
    // host side
    logic                          rd_en;
    logic [DATA_BITS-1:0]          rd_data;
    logic                          rd_valid;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          timeout;
    logic [2:0]                    err_status;

    modport master (
        input  rx_enable, rd_data, rd_valid, fifo_count, fifo_full, fifo_empty,
               timeout, err_status,
        output rx_data, rx_data_ready, rx_frame_error, rx_overrun, rd_en
    );

    modport slave (
        output rx_enable, rd_data, rd_valid, fifo_count, fifo_full, fifo_empty,
               timeout, err_status,
        input  rx_data, rx_data_ready, rx_frame_error, rx_overrun, rd_en
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: arms the receiver after a trusted idle period,
// buffers characters in a show-ahead FIFO, tracks sticky errors and raises
// a character timeout when buffered data sits unread.
module uart_rx_ctrl #(
    parameter int DATA_BITS     = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int OVERSAMPLE    = 16,
    parameter int ARM_BITS      = 10,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cfg_enable,
    input  logic fifo_flush,
    input  logic err_clr,
    input  logic baud_tick,
    input  logic rx_line,
    uart_rx_ctrl_if.slave bus
);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int ARM_MAX = ARM_BITS * OVERSAMPLE - 1;
    localparam int ARM_W   = $clog2(ARM_MAX + 1);
    localparam int TO_MAX  = TIMEOUT_CHARS * 10 * OVERSAMPLE;
    localparam int TO_W    = $clog2(TO_MAX + 1);

    typedef enum logic [1:0] {S_OFF, S_ARM, S_RUN} state_t;

    state_t               state;
    logic [ARM_W-1:0]     arm_cnt;
    logic                 rx_en_q;
    logic                 line_meta, line_sync;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]        count;
    logic [DATA_BITS-1:0] rd_data_q;

    logic [TO_W-1:0]      to_cnt;
    logic                 timeout_q;
    logic [2:0]           err_q;
    logic                 fe_q, ov_q;

    logic run, empty, full, push_req, pop, wr, ovf;
    logic [2:0] err_set;

    assign run        = (state == S_RUN);
    assign empty      = (count == '0);
    assign full       = (count == CW'(FIFO_DEPTH));
    assign push_req   = run && bus.rx_data_ready;
    assign pop        = bus.rd_en && !empty;
    assign wr         = push_req && (!full || pop);
    assign ovf        = push_req && full && !pop;
    assign rd_ptr_nxt = rd_ptr + 1'b1;
    assign err_set    = {run && bus.rx_overrun && !ov_q,
                         run && bus.rx_frame_error && !fe_q,
                         ovf};

    // Two-flop synchronizer on the raw pin; resets to idle (high).
    always_ff @(posedge clk) begin
        if (rst) begin
            line_meta <= 1'b1;
            line_sync <= 1'b1;
        end else begin
            line_meta <= rx_line;
            line_sync <= line_meta;
        end
    end

    // Enable FSM: count idle ticks in ARM before handing the line to the receiver.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_OFF;
            arm_cnt <= '0;
            rx_en_q <= 1'b0;
        end else if (!cfg_enable) begin
            state   <= S_OFF;
            arm_cnt <= '0;
            rx_en_q <= 1'b0;
        end else begin
            case (state)
                S_OFF: begin
                    state   <= S_ARM;
                    arm_cnt <= '0;
                    rx_en_q <= 1'b0;
                end
                S_ARM: begin
                    if (!line_sync) begin
                        arm_cnt <= '0;
                    end else if (baud_tick) begin
                        if (arm_cnt == ARM_W'(ARM_MAX)) begin
                            state   <= S_RUN;
                            arm_cnt <= '0;
                            rx_en_q <= 1'b1;
                        end else begin
                            arm_cnt <= arm_cnt + 1'b1;
                        end
                    end
                end
                S_RUN: rx_en_q <= 1'b1;
                default: begin
                    state   <= S_OFF;
                    rx_en_q <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage; no reset, contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (!rst && !fifo_flush && wr)
            mem[wr_ptr] <= bus.rx_data;
    end

    // Pointers and occupancy; flush beats any push/pop.
    always_ff @(posedge clk) begin
        if (rst || fifo_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr_nxt;
            if (wr && !pop)      count <= count + 1'b1;
            else if (pop && !wr) count <= count - 1'b1;
        end
    end

    // Registered show-ahead head: always holds the entry at rd_ptr.
    always_ff @(posedge clk) begin
        if (rst || fifo_flush) begin
            rd_data_q <= '0;
        end else if (pop) begin
            // With one entry left the next head is the byte arriving now, if any.
            if (count == CW'(1)) begin
                if (wr) rd_data_q <= bus.rx_data;
            end else begin
                rd_data_q <= mem[rd_ptr_nxt];
            end
        end else if (wr && empty) begin
            rd_data_q <= bus.rx_data;
        end
    end

    // Character timeout: ticks while data waits with no host/receiver activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (fifo_flush || !run || push_req || pop)
                to_cnt <= '0;
            else if (baud_tick && !empty && to_cnt != TO_W'(TO_MAX))
                to_cnt <= to_cnt + 1'b1;

            if (fifo_flush || !run || pop)
                timeout_q <= 1'b0;
            else if (baud_tick && !empty && !push_req && to_cnt == TO_W'(TO_MAX - 1))
                timeout_q <= 1'b1;
        end
    end

    // Sticky errors; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
            fe_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            fe_q  <= bus.rx_frame_error;
            ov_q  <= bus.rx_overrun;
            err_q <= (err_q & ~{3{err_clr}}) | err_set;
        end
    end

    assign bus.rx_enable  = rx_en_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = !empty;
    assign bus.fifo_count = count;
    assign bus.fifo_full  = full;
    assign bus.fifo_empty = empty;
    assign bus.timeout    = timeout_q;
    assign bus.err_status = err_q;
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART. It gates the receiver's `enable` until the line has been idle long enough to be trusted, and buffers received characters in a show-ahead FIFO for the host. It also collects sticky error status and raises a character-timeout flag when buffered data sits unread. It sits between the receiver datapath (driven by the shared baud-tick generator) and the host register interface.

## Interface
- DATA_BITS, 8, character width; matches the receiver.
- FIFO_DEPTH, 16, FIFO entries; power of two, at least 2.
- OVERSAMPLE, 16, baud ticks per bit.
- ARM_BITS, 10, number of idle bit-times required before the receiver is enabled.
- TIMEOUT_CHARS, 4, idle character-times (10 bit-times each) before `timeout` asserts.

Ports:
- clk  in  1  single clock for the block.
- rst  in  1  synchronous, active-high reset.
- cfg_enable  in  1  host enable for the receive path.
- fifo_flush  in  1  one-cycle pulse that empties the FIFO.
- err_clr  in  1  one-cycle pulse that clears `err_status`.
- baud_tick  in  1  oversample tick, 1 clk wide.
- rx_line  in  1  raw RX pin, used for idle detection; double-flopped internally.
- rx_enable  out  1  drives the receiver `enable`.
- rx_data  in  DATA_BITS  receiver `data_out`.
- rx_data_ready  in  1  receiver one-cycle strobe.
- rx_frame_error  in  1  receiver frame-error level.
- rx_overrun  in  1  receiver overrun level.
- rd_en  in  1  host pop.
- rd_data  out  DATA_BITS  FIFO head, valid when `rd_valid` is high.
- rd_valid  out  1  equals `!fifo_empty`.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- fifo_full  out  1  asserted when count == FIFO_DEPTH.
- fifo_empty  out  1  asserted when count == 0.
- timeout  out  1  character-timeout flag.
- err_status  out  3  sticky error bits: [0] FIFO overflow, [1] frame error, [2] receiver overrun.

## Operation
- State machine has three states: OFF, ARM, RUN.
  - OFF: `rx_enable`=0. Moves to ARM when `cfg_enable`=1.
  - ARM: `rx_enable`=0. `arm_cnt` increments on each `baud_tick` while the synchronized `rx_line` is 1. `arm_cnt` clears to 0 on any cycle where the synchronized line is 0. Moves to RUN when `arm_cnt` reaches ARM_BITS*OVERSAMPLE-1 on a tick.
  - RUN: `rx_enable`=1.
  - From any state, `cfg_enable`=0 forces OFF on the next edge.
- Push condition: state==RUN and `rx_data_ready`=1.
  - If not full, or a pop occurs in the same cycle, `rx_data` is written.
  - If full and no pop, the byte is dropped and `err_status[0]` is set.
- Pop condition: `rd_en`=1 and not empty. Advances the read pointer. `rd_en` while empty is ignored.
- Simultaneous push and pop leaves `fifo_count` unchanged.
- `fifo_flush` resets both pointers and the count. It overrides any push or pop in the same cycle and also clears `timeout`.
- FIFO contents are retained across OFF. The host may drain the FIFO while disabled.
- `err_status[1]` sets on the rising edge of `rx_frame_error` in RUN. `err_status[2]` sets on the rising edge of `rx_overrun` in RUN.
- `err_clr` clears all three bits. If a set event and `err_clr` fall in the same cycle, the set wins.
- Timeout counter `to_cnt`:
  - Clears on any push, any pop, a flush, or when not in RUN.
  - Otherwise increments on `baud_tick` while the FIFO is non-empty, saturating at TIMEOUT_CHARS*10*OVERSAMPLE.
  - `timeout` sets when `to_cnt` reaches that value.
  - `timeout` clears on a pop, a flush, or leaving RUN.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Occupancy is tracked by a separate counter.

## Timing
- Reset (`rst`=1 at an edge) sets:
  - state OFF, `rx_enable`=0
  - pointers, `fifo_count`, `arm_cnt` and `to_cnt` to 0
  - `fifo_empty`=1, `rd_valid`=0, `fifo_full`=0
  - `timeout`=0, `err_status`=0
  - `rd_data`=0, with RAM contents undefined
  - `rst` overrides every other input.
- `rx_enable` rises one clk after the arming tick. It falls one clk after `cfg_enable` falls.
- Push at edge N: `rd_valid`, `fifo_count` and `rd_data` reflect the new byte after edge N, with no extra latency when the FIFO was empty.
- Pop at edge N: the next entry appears on `rd_data` after edge N.
- `timeout` asserts the cycle after the threshold tick.
- Error bits assert the cycle after the triggering edge.
- The synchronizer adds 2 clk of latency to `rx_line` observation in ARM.

## Test plan
- Reset, `cfg_enable`=1, `rx_line` held high: `rx_enable` rises exactly 1 clk after the 160th `baud_tick`. Driving `rx_line` low at tick 100 restarts the count.
- In RUN, push 0xA5, 0x3C, 0xFF: `fifo_count`=3 and `rd_data`=0xA5. Three pops return A5, 3C, FF, after which `fifo_empty`=1.
- Fill 16 entries, then push 0x55 without a pop: byte dropped, `err_status`=3'b001, count stays 16. Repeat with a simultaneous pop: 0x55 is accepted, count stays 16. `err_clr` then gives `err_status`=0.
- One byte buffered with no reads: `timeout` asserts after 640 ticks. A pop clears it. A push at tick 639 restarts the count.
- Pulse `rx_frame_error` and `rx_overrun` in RUN: `err_status`=3'b110. `err_clr` in the same cycle as a new frame-error edge leaves bit 1 set.
- Deassert `cfg_enable` mid-RUN with 2 bytes buffered: `rx_enable`=0 next clk, pushes are ignored, and the host still reads both bytes. `rst` asserted mid-fill returns every output to its reset value.
